keccak_obi_xbar_arbiter: RTL

- Shares the single external OBI slave port (Keccak accelerator context/data memory, index 0, 1 MiB window at EXT_SLAVE_START_ADDRESS) between the EXT_XBAR_NMASTER=4 external master ports.
- Round-robin arbitration with request locking, so the slave-side request stays OBI-stable until it is granted.
- Tracks outstanding transactions in an index FIFO and routes each rvalid/rdata back to the master that issued it.
- Sits between the external master ports and the accelerator's memory slave inside the keccak_x_heep subsystem.

---
 rtl/keccak_obi_xbar_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_obi_xbar_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// keccak_obi_xbar_arbiter
//
// Shares one OBI slave port (the Keccak accelerator memory) between NMASTER
// OBI master ports. Round-robin selection with a request lock, so that once
// the slave has seen a request it keeps seeing the same one until it grants.
// Every granted transaction pushes the issuing master index into a small FIFO.
// Responses (assumed in grant order) pop that FIFO to steer rvalid back to the
// right master.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   m_req_i/m_addr_i/...   per-master OBI request channel (master k at slice k)
//   m_gnt_o, m_rvalid_o    per-master grant / response valid
//   m_rdata_o              response data, broadcast to all masters
//   s_*                    OBI slave request/response channel
//   outstanding_o          number of granted transactions awaiting rvalid
//   err_o                  sticky: rvalid seen with no outstanding transaction
// ---------------------------------------------------------------------------
module keccak_obi_xbar_arbiter #(
    parameter int NMASTER         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NMASTER-1:0]                     m_req_i,
    input  logic [NMASTER*ADDR_WIDTH-1:0]          m_addr_i,
    input  logic [NMASTER-1:0]                     m_we_i,
    input  logic [NMASTER*DATA_WIDTH/8-1:0]        m_be_i,
    input  logic [NMASTER*DATA_WIDTH-1:0]          m_wdata_i,
    output logic [NMASTER-1:0]                     m_gnt_o,
    output logic [NMASTER-1:0]                     m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  m_rdata_o,
    output logic                                   s_req_o,
    output logic [ADDR_WIDTH-1:0]                  s_addr_o,
    output logic                                   s_we_o,
    output logic [DATA_WIDTH/8-1:0]                s_be_o,
    output logic [DATA_WIDTH-1:0]                  s_wdata_o,
    input  logic                                   s_gnt_i,
    input  logic                                   s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int IDX_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    // State
    logic [IDX_W-1:0] rr_ptr_reg,     rr_ptr_next;
    logic             lock_valid_reg, lock_valid_next;
    logic [IDX_W-1:0] lock_idx_reg,   lock_idx_next;
    logic [PTR_W-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg,     rd_ptr_next;
    logic [CNT_W-1:0] count_reg,      count_next;
    logic             err_reg,        err_next;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];

    // Per-master payload views
    logic [ADDR_WIDTH-1:0] addr_arr  [NMASTER];
    logic [BE_W-1:0]       be_arr    [NMASTER];
    logic [DATA_WIDTH-1:0] wdata_arr [NMASTER];

    generate
        for (genvar gi = 0; gi < NMASTER; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]    = m_be_i[gi*BE_W +: BE_W];
            assign wdata_arr[gi] = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin scan: first requester at or after rr_ptr, wrapping.
    logic [IDX_W-1:0] rr_sel;
    logic             rr_found;
    int               cand;

    always_comb begin
        rr_sel   = rr_ptr_reg;
        rr_found = 1'b0;
        cand     = 0;
        for (int i = 0; i < NMASTER; i++) begin
            cand = (int'(rr_ptr_reg) + i) % NMASTER;
            if (!rr_found && m_req_i[cand]) begin
                rr_found = 1'b1;
                rr_sel   = IDX_W'(cand);
            end
        end
    end

    logic [IDX_W-1:0] sel;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             hs;
    logic             pop;
    logic [IDX_W-1:0] head;

    // A pending (locked) request wins over the scan so the slave-side
    // request cannot change while it waits for gnt.
    assign sel     = lock_valid_reg ? lock_idx_reg : rr_sel;
    assign any_req = lock_valid_reg | (|m_req_i);
    assign full    = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (count_reg == '0);
    assign s_req_o = any_req & ~full;
    assign hs      = s_req_o & s_gnt_i;
    assign pop     = s_rvalid_i & ~empty;
    assign head    = fifo_mem[rd_ptr_reg];

    assign s_addr_o  = addr_arr[sel];
    assign s_we_o    = m_we_i[sel];
    assign s_be_o    = be_arr[sel];
    assign s_wdata_o = wdata_arr[sel];

    generate
        for (genvar gi = 0; gi < NMASTER; gi++) begin : g_route
            assign m_gnt_o[gi]    = hs  & (sel  == IDX_W'(gi));
            assign m_rvalid_o[gi] = pop & (head == IDX_W'(gi));
        end
    endgenerate

    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = count_reg;
    assign err_o         = err_reg;

    // Next-state logic
    always_comb begin
        rr_ptr_next     = rr_ptr_reg;
        lock_valid_next = lock_valid_reg;
        lock_idx_next   = lock_idx_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg + CNT_W'(hs) - CNT_W'(pop);
        err_next        = err_reg | (s_rvalid_i & empty);

        if (hs) begin
            rr_ptr_next     = (sel == IDX_W'(NMASTER - 1)) ? '0 : sel + 1'b1;
            lock_valid_next = 1'b0;
            wr_ptr_next     = (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end else if (s_req_o) begin
            lock_valid_next = 1'b1;
            lock_idx_next   = sel;
        end

        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg     <= '0;
            lock_valid_reg <= 1'b0;
            lock_idx_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            rr_ptr_reg     <= rr_ptr_next;
            lock_valid_reg <= lock_valid_next;
            lock_idx_reg   <= lock_idx_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            err_reg        <= err_next;
        end
    end

    // Index storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_mem[wr_ptr_reg] <= sel;
        end
    end

endmodule
